// File: rtl/multicycle_ctrl_if.sv
// Memory-port handshake between the multicycle control FSM and the
// unified instruction/data memory.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_write;
    logic adr_src;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        output adr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  adr_src,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: main/ALU decode, immediate select,
// memory wait timeout, illegal-opcode trap and retired-instruction count.
module multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    multicycle_ctrl_if.master bus,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [1:0]       imm_src,
    output logic             illegal_op,
    output logic             mem_fault,
    output logic [CNT_W-1:0] instret
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_FN  = 2'b10
    } alu_op_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       reg_write;
        logic       fetch;
        logic       beq;
        logic       jal;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        alu_op_t    alu_op;
    } ctrl_t;

    function automatic ctrl_t decode(state_t s);
        ctrl_t c;
        c = '0;
        unique case (s)
            FETCH: begin
                c.mem_req    = 1'b1;
                c.fetch      = 1'b1;
                c.src_b      = 2'b10;
                c.result_src = 2'b10;
            end
            DECODE: begin
                c.src_a = 2'b01;
                c.src_b = 2'b01;
            end
            MEMADR: begin
                c.src_a = 2'b10;
                c.src_b = 2'b01;
            end
            MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            EXECR: begin
                c.src_a  = 2'b10;
                c.alu_op = ALU_FN;
            end
            EXECI: begin
                c.src_a  = 2'b10;
                c.src_b  = 2'b01;
                c.alu_op = ALU_FN;
            end
            ALUWB: c.reg_write = 1'b1;
            BEQ: begin
                c.src_a  = 2'b10;
                c.alu_op = ALU_SUB;
                c.beq    = 1'b1;
            end
            JAL: begin
                c.src_a = 2'b01;
                c.src_b = 2'b10;
                c.jal   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t            state, state_n;
    ctrl_t             ctl;
    logic [WW-1:0]     wcnt;
    logic              is_mem, timeout, fault, illegal, retire;

    assign timeout = !bus.mem_ready && (wcnt == WW'(MEM_TIMEOUT - 1));

    always_comb begin
        state_n = state;
        is_mem  = 1'b0;
        fault   = 1'b0;
        illegal = 1'b0;
        unique case (state)
            FETCH, MEMREAD, MEMWRITE: begin
                is_mem = 1'b1;
                if (bus.mem_ready) begin
                    unique case (state)
                        FETCH:   state_n = DECODE;
                        MEMREAD: state_n = MEMWB;
                        default: state_n = FETCH;
                    endcase
                end else if (timeout) begin
                    state_n = TRAP;
                    fault   = 1'b1;
                end
            end
            DECODE: begin
                unique case (op)
                    OP_LW, OP_SW: state_n = MEMADR;
                    OP_R:         state_n = EXECR;
                    OP_I:         state_n = EXECI;
                    OP_BEQ:       state_n = BEQ;
                    OP_JAL:       state_n = JAL;
                    default: begin
                        state_n = TRAP;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR:       state_n = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMWB:        state_n = FETCH;
            EXECR, EXECI: state_n = ALUWB;
            ALUWB:        state_n = FETCH;
            BEQ:          state_n = FETCH;
            JAL:          state_n = ALUWB;
            default:      state_n = TRAP;
        endcase
    end

    assign retire = (state_n == FETCH) &&
                    (state inside {MEMWB, MEMWRITE, ALUWB, BEQ});

    // Outputs for the coming state are registered alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FETCH;
            ctl        <= decode(FETCH);
            wcnt       <= '0;
            instret    <= '0;
            illegal_op <= 1'b0;
            mem_fault  <= 1'b0;
        end else begin
            state <= state_n;
            ctl   <= decode(state_n);
            if (state_n != state)
                wcnt <= '0;
            else if (is_mem && !bus.mem_ready)
                wcnt <= wcnt + WW'(1);
            if (retire)
                instret <= instret + CNT_W'(1);
            if (illegal)
                illegal_op <= 1'b1;
            if (fault)
                mem_fault <= 1'b1;
        end
    end

    assign bus.mem_req   = reset_n & ctl.mem_req;
    assign bus.mem_write = reset_n & ctl.mem_write;
    assign bus.adr_src   = ctl.adr_src;
    assign reg_write     = reset_n & ctl.reg_write;
    assign ir_write      = reset_n & ctl.fetch & bus.mem_ready;
    assign pc_write      = reset_n & ((ctl.fetch & bus.mem_ready) |
                                      (ctl.beq & zero) | ctl.jal);
    assign result_src    = ctl.result_src;
    assign alu_src_a     = ctl.src_a;
    assign alu_src_b     = ctl.src_b;

    always_comb begin
        alu_control = 3'b000;
        unique case (ctl.alu_op)
            ALU_SUB: alu_control = 3'b001;
            ALU_FN: begin
                unique case (funct3)
                    3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        unique case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

endmodule
